// File: rtl/controlador_parqueo_param_if.sv
`default_nettype none
// ============================================================================
// Module      : controlador_parqueo_param_if
// Description : Gate sensor / keypad / actuator bundle for one parking
//               entry gate.
//                 master : sensors and keypad side (drives the inputs)
//                 slave  : gate controller (drives the gate status)
//               Inputs : Vehiculo, Termino, enterPin, Pin[PIN_W], Salida
//               Status : Cerrado, Abierto, Alarma, Bloqueo, Lleno,
//                        Ocupacion[OCC_W], Intentos[4]
// Revision    : 1.0  initial release
// ============================================================================
interface controlador_parqueo_param_if #(
    parameter int PIN_W = 8,
    parameter int OCC_W = 3
);
    logic             Vehiculo;
    logic             Termino;
    logic             enterPin;
    logic [PIN_W-1:0] Pin;
    logic             Salida;
    logic             Cerrado;
    logic             Abierto;
    logic             Alarma;
    logic             Bloqueo;
    logic             Lleno;
    logic [OCC_W-1:0] Ocupacion;
    logic [3:0]       Intentos;

    modport master (
        output Vehiculo, Termino, enterPin, Pin, Salida,
        input  Cerrado, Abierto, Alarma, Bloqueo, Lleno, Ocupacion, Intentos
    );

    modport slave (
        input  Vehiculo, Termino, enterPin, Pin, Salida,
        output Cerrado, Abierto, Alarma, Bloqueo, Lleno, Ocupacion, Intentos
    );
endinterface
`default_nettype wire

// File: rtl/controlador_parqueo_param.sv
`default_nettype none
// ============================================================================
// Module      : controlador_parqueo_param
// Description : Parametrised parking-gate controller. PIN entry with
//               wrong-attempt counting and alarm, tailgating lockout,
//               gate-open timeout and lot-occupancy tracking.
//   Clk    : clock, all state on the rising edge
//   Reset  : synchronous, active-high reset
//   bus    : slave side of controlador_parqueo_param_if
//            (Vehiculo, Termino, enterPin, Pin, Salida in;
//             Cerrado, Abierto, Alarma, Bloqueo, Lleno, Ocupacion,
//             Intentos out -- all outputs combinational from state+inputs)
// Revision    : 1.0  initial release
// ============================================================================
module controlador_parqueo_param #(
    parameter int               PIN_W     = 8,
    parameter logic [PIN_W-1:0] PIN_OK    = 8'b00010000,
    parameter int               MAX_TRIES = 3,
    parameter int               OPEN_TO   = 16,
    parameter int               CAP       = 4,
    parameter int               OCC_W     = 3
) (
    input  wire logic                  Clk,
    input  wire logic                  Reset,
    controlador_parqueo_param_if.slave bus
);

    localparam int TIMER_W = $clog2(OPEN_TO);

    localparam logic [3:0]         c_max_tries  = 4'(MAX_TRIES);
    localparam logic [TIMER_W-1:0] c_timer_last = TIMER_W'(OPEN_TO - 1);
    localparam logic [OCC_W-1:0]   c_cap        = OCC_W'(CAP);
    localparam logic [OCC_W-1:0]   c_occ_one    = OCC_W'(1);

    typedef enum logic [2:0] {
        CERRADA   = 3'b001,
        ABIERTA   = 3'b010,
        BLOQUEADA = 3'b100
    } state_t;

    state_t             r_state;
    logic [3:0]         r_tries;
    logic [TIMER_W-1:0] r_timer;
    logic [OCC_W-1:0]   r_occ;

    logic               w_lleno;
    logic               w_pin_ok;
    logic               w_timer_last;
    logic               w_closing;
    logic               w_inc;
    logic [OCC_W-1:0]   w_occ_next;
    logic               w_cerrado;
    logic               w_abierto;
    logic               w_alarma;
    logic               w_bloqueo;

    assign w_lleno      = (r_occ == c_cap);
    assign w_pin_ok     = (bus.Pin == PIN_OK);
    assign w_timer_last = (r_timer == c_timer_last);

    // The gate starts closing in the very cycle the vehicle finishes or the
    // open window expires, so the status outputs flip before the state does.
    assign w_closing = (r_state == ABIERTA) && (bus.Termino || w_timer_last);

    // A car is counted in only on the Termino cycle of an open gate.
    assign w_inc = (r_state == ABIERTA) && bus.Termino;

    // Occupancy update. Entry and exit in the same cycle cancel, except on
    // an empty lot where the exit cannot be honoured but the entry can.
    always_comb begin
        w_occ_next = r_occ;
        if (w_inc && bus.Salida) begin
            if (r_occ == '0) begin
                w_occ_next = c_occ_one;
            end
        end else if (w_inc) begin
            if (r_occ != c_cap) begin
                w_occ_next = r_occ + c_occ_one;
            end
        end else if (bus.Salida) begin
            if (r_occ != '0) begin
                w_occ_next = r_occ - c_occ_one;
            end
        end
    end

    // Mealy status outputs; an illegal state reads as a closed gate.
    always_comb begin
        w_cerrado = 1'b1;
        w_abierto = 1'b0;
        w_alarma  = 1'b0;
        w_bloqueo = 1'b0;
        case (r_state)
            CERRADA: begin
                w_alarma = bus.Vehiculo && (r_tries >= c_max_tries);
            end
            ABIERTA: begin
                w_cerrado = w_closing;
                w_abierto = !w_closing;
            end
            BLOQUEADA: begin
                w_cerrado = 1'b0;
                w_alarma  = 1'b1;
                w_bloqueo = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= CERRADA;
            r_tries <= '0;
            r_timer <= '0;
            r_occ   <= '0;
        end else begin
            r_occ <= w_occ_next;
            case (r_state)
                CERRADA: begin
                    // A full lot or an absent vehicle makes the keypad inert.
                    if (bus.Vehiculo && bus.enterPin && !w_lleno) begin
                        if (w_pin_ok) begin
                            r_state <= ABIERTA;
                            r_tries <= '0;
                            r_timer <= '0;
                        end else if (r_tries < c_max_tries) begin
                            r_tries <= r_tries + 4'd1;
                        end
                    end
                end
                ABIERTA: begin
                    r_tries <= '0;
                    r_timer <= r_timer + TIMER_W'(1);
                    // Termino wins over the timeout when both occur.
                    if (bus.Termino) begin
                        r_state <= bus.Vehiculo ? BLOQUEADA : CERRADA;
                    end else if (w_timer_last) begin
                        r_state <= CERRADA;
                    end
                end
                BLOQUEADA: begin
                    // Supervisor override: a correct PIN reopens even if full.
                    if (bus.enterPin && w_pin_ok) begin
                        r_state <= ABIERTA;
                        r_tries <= '0;
                        r_timer <= '0;
                    end
                end
                default: begin
                    r_state <= CERRADA;
                end
            endcase
        end
    end

    assign bus.Cerrado   = w_cerrado;
    assign bus.Abierto   = w_abierto;
    assign bus.Alarma    = w_alarma;
    assign bus.Bloqueo   = w_bloqueo;
    assign bus.Lleno     = w_lleno;
    assign bus.Ocupacion = r_occ;
    assign bus.Intentos  = r_tries;

endmodule
`default_nettype wire

// File: tb/tb_controlador_parqueo_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_controlador_parqueo_param
// Description : Scoreboard bench for controlador_parqueo_param. The driver
//               applies directed then random stimulus, computes the expected
//               gate status from a behavioural model of the lot and pushes it
//               into a queue; a monitor pops and compares each cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_controlador_parqueo_param;

    localparam int         PIN_W     = 8;
    localparam logic [7:0] PIN_OK    = 8'h10;
    localparam logic [7:0] PIN_BAD   = 8'h11;
    localparam int         MAX_TRIES = 3;
    localparam int         OPEN_TO   = 16;
    localparam int         CAP       = 4;
    localparam int         OCC_W     = 3;

    // Model gate conditions
    localparam int M_SHUT = 0;
    localparam int M_OPEN = 1;
    localparam int M_LOCK = 2;

    typedef struct {
        bit c;
        bit a;
        bit al;
        bit b;
        bit l;
        int occ;
        int tries;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cyc_no;
    exp_t q[$];

    // Behavioural model of the gate and lot
    int m_gate;
    int m_tries;
    int m_open_cycles;
    int m_occ;

    controlador_parqueo_param_if #(.PIN_W(PIN_W), .OCC_W(OCC_W)) bus ();

    controlador_parqueo_param #(
        .PIN_W    (PIN_W),
        .PIN_OK   (PIN_OK),
        .MAX_TRIES(MAX_TRIES),
        .OPEN_TO  (OPEN_TO),
        .CAP      (CAP),
        .OCC_W    (OCC_W)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle of stimulus; outputs for this cycle are predicted from
    // the model before its state advances.
    task automatic cyc(input bit v, input bit t, input bit e,
                       input logic [7:0] p, input bit s, input bit r);
        exp_t x;
        bit   leaving;
        int   next_gate;
        bit   car_in;
        @(posedge clk);
        #1;
        rst          = r;
        bus.Vehiculo = v;
        bus.Termino  = t;
        bus.enterPin = e;
        bus.Pin      = p;
        bus.Salida   = s;
        cyc_no++;
        if (r) begin
            m_gate        = M_SHUT;
            m_tries       = 0;
            m_open_cycles = 0;
            m_occ         = 0;
        end else begin
            x.cyc   = cyc_no;
            x.occ   = m_occ;
            x.tries = m_tries;
            x.l     = (m_occ == CAP);
            next_gate = m_gate;
            car_in    = 1'b0;
            if (m_gate == M_SHUT) begin
                x.c = 1; x.a = 0; x.b = 0;
                x.al = v && (m_tries >= MAX_TRIES);
                if (v && e && !x.l) begin
                    if (p == PIN_OK) begin
                        next_gate     = M_OPEN;
                        m_tries       = 0;
                        m_open_cycles = 0;
                    end else if (m_tries < MAX_TRIES) begin
                        m_tries = m_tries + 1;
                    end
                end
            end else if (m_gate == M_OPEN) begin
                leaving = t || (m_open_cycles == OPEN_TO - 1);
                x.c = leaving; x.a = !leaving; x.al = 0; x.b = 0;
                m_tries = 0;
                if (t) begin
                    car_in    = 1'b1;
                    next_gate = v ? M_LOCK : M_SHUT;
                end else if (m_open_cycles == OPEN_TO - 1) begin
                    next_gate = M_SHUT;
                end
                m_open_cycles = m_open_cycles + 1;
            end else begin
                x.c = 0; x.a = 0; x.al = 1; x.b = 1;
                if (e && p == PIN_OK) begin
                    next_gate     = M_OPEN;
                    m_tries       = 0;
                    m_open_cycles = 0;
                end
            end
            m_gate = next_gate;
            if (car_in && s) begin
                if (m_occ == 0) m_occ = 1;
            end else begin
                m_occ = m_occ + (car_in ? 1 : 0) - (s ? 1 : 0);
                if (m_occ > CAP) m_occ = CAP;
                if (m_occ < 0)   m_occ = 0;
            end
            q.push_back(x);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'h00, 0, 0);
    endtask

    task automatic car_enters();
        cyc(1, 0, 1, PIN_OK, 0, 0);
        cyc(0, 1, 0, 8'h00, 0, 0);
    endtask

    // Monitor: every cycle the DUT presents its status; compare against the
    // oldest outstanding prediction.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks++;
            if (bus.Cerrado !== e.c || bus.Abierto !== e.a ||
                bus.Alarma !== e.al || bus.Bloqueo !== e.b ||
                bus.Lleno !== e.l ||
                bus.Ocupacion !== OCC_W'(e.occ) ||
                bus.Intentos !== 4'(e.tries)) begin
                errors++;
                $display("FAIL gate_status cyc=%0d got C=%0b A=%0b Al=%0b B=%0b L=%0b occ=%0d tries=%0d exp C=%0b A=%0b Al=%0b B=%0b L=%0b occ=%0d tries=%0d",
                         e.cyc, bus.Cerrado, bus.Abierto, bus.Alarma, bus.Bloqueo,
                         bus.Lleno, bus.Ocupacion, bus.Intentos,
                         e.c, e.a, e.al, e.b, e.l, e.occ, e.tries);
            end
        end
    end

    initial begin
        logic [7:0] p;
        checks = 0;
        errors = 0;
        cyc_no = 0;
        rst = 1'b1;
        bus.Vehiculo = 0; bus.Termino = 0; bus.enterPin = 0;
        bus.Pin = 8'h00; bus.Salida = 0;
        m_gate = M_SHUT; m_tries = 0; m_open_cycles = 0; m_occ = 0;

        // Reset with noisy inputs, then observe the reset state
        cyc(1, 1, 1, PIN_OK, 1, 1);
        cyc(1, 0, 1, PIN_OK, 0, 1);
        idle(1);

        // Correct PIN opens; clean pass closes and counts one car
        cyc(1, 0, 1, PIN_OK, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 0, 8'h00, 0, 0);
        idle(1);

        // Wrong PINs count up and saturate, alarm with vehicle present
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, PIN_BAD, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 1, PIN_BAD, 0, 0);
        cyc(1, 0, 1, PIN_OK, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 0);

        // Tailgating locks the gate; wrong PIN ignored; reset while locked
        cyc(1, 1, 0, 8'h00, 0, 0);
        cyc(1, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 1, PIN_BAD, 0, 0);
        cyc(0, 0, 0, 8'h00, 0, 1);
        idle(1);

        // Lock again, reopen with correct PIN, then let the gate time out
        car_enters();
        cyc(1, 0, 1, PIN_OK, 0, 0);
        cyc(1, 1, 0, 8'h00, 0, 0);
        cyc(0, 0, 1, PIN_BAD, 0, 0);
        cyc(0, 0, 1, PIN_OK, 0, 0);
        idle(OPEN_TO + 2);

        // Fill the lot; keypad ignored while full; exits drain to zero
        for (int i = 0; i < CAP; i++) car_enters();
        cyc(1, 0, 1, PIN_OK, 0, 0);
        cyc(1, 0, 1, PIN_BAD, 0, 0);
        cyc(1, 0, 0, 8'h00, 1, 0);
        for (int i = 0; i < CAP + 1; i++) cyc(0, 0, 0, 8'h00, 1, 0);

        // Entry and exit in the same cycle on an empty lot, then on a non-empty one
        cyc(1, 0, 1, PIN_OK, 0, 0);
        cyc(0, 1, 0, 8'h00, 1, 0);
        cyc(1, 0, 1, PIN_OK, 0, 0);
        cyc(0, 1, 0, 8'h00, 1, 0);
        idle(1);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            p = ($urandom_range(0, 1) == 0) ? PIN_OK : 8'($urandom());
            cyc(($urandom_range(0, 3) != 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0),
                p,
                ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 99) == 0));
        end

        // Let the monitor drain the scoreboard
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending, need 0", q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
